uart_tx_buffered: RTL
=====================

Name: uart_tx_buffered

Overview:
- Buffered UART transmitter: 8N1, no parity, no flow control, LSB first.
- Pairs with the existing receive path inside the UART peripheral; the CPU writes bytes into an internal FIFO through the memory-mapped bus.
- A serializer drains the FIFO back-to-back at clk_freq/BAUD_RATE.
- Raises a "transmit drained" interrupt, cleared by a register write at a fixed bus address.

Parameters:
- BAUD_RATE, 115200, serial bit rate in bit/s.
- DEPTH, 8, FIFO entries; must be a power of two, minimum 2.
- INT_CLR_ADDR, 8'd253, bus address whose write clears int_req and overflow.

Ports:
- clk  input  1  system clock; all state updates on the falling edge.
- reset  input  1  reset, synchronous, active-high.
- tx_en  input  1  permits starting new frames.
- wr_en  input  1  push wr_data into FIFO this cycle.
- wr_data  input  8  byte to enqueue.
- access_addr  input  8  bus address of the current CPU access.
- reg_w_en  input  1  CPU register write strobe.
- clk_freq  input  32  system clock frequency in Hz.
- tx  output  1  serial line, idle high.
- busy  output  1  serializer not idle.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky flag: a push was dropped.
- int_req  output  1  transmit-drained interrupt, level.

Behaviour:
- Reset values:
  - tx=1, busy=0, full=0, empty=1, level=0, overflow=0, int_req=0.
  - FSM in IDLE; FIFO pointers cleared.
  - Reset mid-frame aborts the frame; tx returns high on the same edge.
- Bit period:
  - N = clk_freq / BAUD_RATE, 32-bit unsigned integer division, combinational.
  - N==0 is treated as N=1.
  - Each bit holds tx for exactly N clk cycles; one frame is 10N cycles.
- FIFO:
  - Push when wr_en && !full.
  - wr_en while full: byte dropped, overflow set to 1. full is evaluated before any same-cycle pop.
  - Simultaneous push and pop both take effect; level unchanged.
  - Pointers wrap modulo DEPTH.
  - level, full and empty are registered and consistent on the same edge.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If tx_en && !empty: pop head into an 8-bit shift register, clear bit counter and baud counter, go to START. Pop and the tx falling edge happen on the same clk edge.
  - START: tx=0 for N cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for N cycles, then shift right and increment index. After index 7 completes, go to STOP.
  - STOP: tx=1 for N cycles. At the end of STOP:
    - if tx_en && !empty: pop and go directly to START (no idle gap between frames);
    - otherwise go to IDLE.
  - busy = (state != IDLE).
  - tx_en deasserted mid-frame: current frame completes; no new frame starts.
  - tx is driven from a register (glitch-free).
- Latency: a byte pushed at edge k with FSM idle and tx_en=1 is popped at edge k+1; the start bit begins at edge k+1.
- Interrupt and flag clearing:
  - int_req sets when STOP completes and FIFO is empty with no push on that edge.
  - int_req and overflow clear on an edge where reg_w_en && access_addr==INT_CLR_ADDR.
  - If a set condition and a clear occur on the same edge, set wins.
- clk_freq changes: take effect at the next bit boundary; no requirement mid-bit.

Test Plan:
- Single byte: clk_freq=1_152_000 (N=10), tx_en=1, push 8'hA5 -> tx low 10 cycles, then 1,0,1,0,0,1,0,1 for 10 cycles each, then high 10 cycles. busy high for exactly 100 cycles. int_req rises at the end of STOP.
- Back-to-back: push 8'h55, 8'h0F, 8'hF0 in consecutive cycles -> level peaks at 2, then reaches 0. Three contiguous frames totalling 300 cycles with no idle gap. int_req set once, after the third stop bit.
- Overflow: tx_en=0, push 9 bytes (DEPTH=8) -> full=1, level=8, overflow=1, ninth byte absent. With tx_en=1, the first 8 bytes are transmitted in push order.
- Interrupt clear: with int_req=1, reg_w_en=1 at access_addr=253 -> int_req=0 and overflow=0 next edge. Write to address 252 -> no change. A clear coinciding with a drain completion leaves int_req=1.
- Gating and reset: deassert tx_en during DATA of the first of 2 queued bytes -> first frame completes, second stays queued (level=1). Assert reset mid-frame -> tx=1, level=0, busy=0 on the next edge.
- N==0 boundary: clk_freq=100_000 -> each bit lasts 1 cycle; a frame lasts 10 cycles.

Source files
------------

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte FIFO drained back-to-back by a serializer
// running at clk_freq/BAUD_RATE, with a sticky overflow flag and a drain interrupt.
module uart_tx_buffered #(
  parameter int unsigned BAUD_RATE    = 115200,
  parameter int unsigned DEPTH        = 8,
  parameter logic [7:0]  INT_CLR_ADDR = 8'd253
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tx_en,
  input  logic                       wr_en,
  input  logic [7:0]                 wr_data,
  input  logic [7:0]                 access_addr,
  input  logic                       reg_w_en,
  input  logic [31:0]                clk_freq,
  output logic                       tx,
  output logic                       busy,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic                       int_req
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [31:0]   n_div, n_bit, baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg, shift_nxt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_r, level_nxt;
  logic          full_r, empty_r, overflow_r, int_req_r, tx_r;
  logic          push, pop, bit_done, tx_nxt, clr_hit, drain_done;

  // A zero quotient (clock slower than the baud rate) still advances one bit per cycle.
  assign n_div    = clk_freq / BAUD_RATE;
  assign n_bit    = (n_div == 32'd0) ? 32'd1 : n_div;
  assign bit_done = (baud_cnt >= n_bit - 32'd1);

  assign push       = wr_en && !full_r;
  assign clr_hit    = reg_w_en && (access_addr == INT_CLR_ADDR);
  assign drain_done = (state == STOP) && bit_done && empty_r && !push;

  // NOTE: every variable assigned in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE:  if (tx_en && !empty_r) begin
               pop       = 1'b1;
               state_nxt = START;
             end
      START: if (bit_done) state_nxt = DATA;
      DATA:  if (bit_done && bit_idx == 3'd7) state_nxt = STOP;
      STOP:  if (bit_done) begin
               if (tx_en && !empty_r) begin
                 pop       = 1'b1;
                 state_nxt = START;
               end else begin
                 state_nxt = IDLE;
               end
             end
      default: state_nxt = IDLE;
    endcase
  end

  // tx is computed from the next state so the register changes on the same edge as the state.
  always_comb begin
    shift_nxt = shift_reg;
    tx_nxt    = 1'b1;
    if (pop)
      shift_nxt = mem[rd_ptr];
    else if (state == DATA && bit_done)
      shift_nxt = {1'b0, shift_reg[7:1]};
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(negedge clk) begin
    if (reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx_r      <= 1'b1;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      tx_r      <= tx_nxt;
      if (state == IDLE || bit_done)
        baud_cnt <= '0;
      else
        baud_cnt <= baud_cnt + 32'd1;
      if (state != DATA)
        bit_idx <= '0;
      else if (bit_done)
        bit_idx <= bit_idx + 3'd1;
    end
  end

  // NOTE: the FIFO storage has no reset; only the pointers and occupancy define valid contents.
  always_ff @(negedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_comb begin
    level_nxt = level_r + LW'(push) - LW'(pop);
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_r <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level_r <= level_nxt;
      full_r  <= (level_nxt == LW'(DEPTH));
      empty_r <= (level_nxt == '0);
    end
  end

  // Set has priority over a coincident clear write.
  always_ff @(negedge clk) begin
    if (reset) begin
      overflow_r <= 1'b0;
      int_req_r  <= 1'b0;
    end else begin
      if (wr_en && full_r) overflow_r <= 1'b1;
      else if (clr_hit)    overflow_r <= 1'b0;
      if (drain_done)      int_req_r  <= 1'b1;
      else if (clr_hit)    int_req_r  <= 1'b0;
    end
  end

  assign tx       = tx_r;
  assign busy     = (state != IDLE);
  assign full     = full_r;
  assign empty    = empty_r;
  assign level    = level_r;
  assign overflow = overflow_r;
  assign int_req  = int_req_r;

endmodule
